lsu_riscv: RTL and testbench

LSU_RISCV -- requirements
Module: lsu_riscv

---
 rtl/lsu_riscv.sv | 179 +++++++++++++++++
 tb/tb_lsu_riscv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_riscv.sv
// Load/store unit for a RISC-V core: checks each memory instruction for a
// legal size and natural alignment, issues one word-addressed memory access
// with byte enables and lane-replicated store data, holds the core until the
// memory answers or the wait budget runs out, and extends the loaded lane.
module lsu_riscv #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misaligned_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        req_q;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [29:0] waddr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;

    logic        size_legal;
    logic        misaligned;
    logic        accept;
    logic        finish;
    logic        stall;
    logic        mis_pulse;
    logic        err_pulse;
    logic [31:0] rd_data;
    logic [3:0]  be_d;
    logic [31:0] wd_d;

    // Byte enables depend only on width and the low address bits; loads share them.
    function automatic logic [3:0] gen_be(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated so the memory finds it in whichever lane is enabled.
    function automatic logic [31:0] gen_wd(input logic [1:0] width, input logic [31:0] wd);
        case (width)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Shift the addressed lane down, then sign- or zero-extend by funct3[2].
    function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] lane;
        lane = word >> {off, 3'b000};
        case (size[1:0])
            2'b00:   return size[2] ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   return size[2] ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: return word;
        endcase
    endfunction

    assign size_legal = (core_size_i == 3'b000) || (core_size_i == 3'b001) ||
                        (core_size_i == 3'b010) || (core_size_i == 3'b100) ||
                        (core_size_i == 3'b101);
    assign misaligned = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                        ((core_size_i[1:0] == 2'b10) && (core_addr_i[1:0] != 2'b00));
    assign be_d       = gen_be(core_size_i[1:0], core_addr_i[1:0]);
    assign wd_d       = gen_wd(core_size_i[1:0], core_wd_i);

    // Same-cycle request checks in IDLE; completion, timeout and stall in BUSY.
    always_comb begin
        accept    = 1'b0;
        finish    = 1'b0;
        stall     = 1'b0;
        mis_pulse = 1'b0;
        err_pulse = 1'b0;
        rd_data   = 32'd0;
        if (state_q == IDLE) begin
            if (core_req_i) begin
                if (!size_legal) begin
                    err_pulse = 1'b1;
                end else if (misaligned) begin
                    mis_pulse = 1'b1;
                end else begin
                    accept = 1'b1;
                    stall  = 1'b1;
                end
            end
        end else if (mem_ready_i) begin
            // Ready wins over a timeout landing in the same cycle.
            finish = 1'b1;
            if (!we_q) begin
                rd_data = load_ext(size_q, off_q, mem_rd_i);
            end
        end else if (cnt_q == TIMEOUT) begin
            finish    = 1'b1;
            err_pulse = 1'b1;
        end else begin
            stall = 1'b1;
        end
    end

    // Core-facing outputs are forced quiet while reset is asserted.
    assign core_stall_o      = rst_ni & stall;
    assign core_misaligned_o = rst_ni & mis_pulse;
    assign core_err_o        = rst_ni & err_pulse;
    assign core_rd_o         = rst_ni ? rd_data : 32'd0;

    assign mem_req_o  = req_q;
    assign mem_we_o   = we_q;
    assign mem_be_o   = be_q;
    assign mem_addr_o = {waddr_q, 2'b00};
    assign mem_wd_o   = wd_q;

    // FSM with the latched access and the registered memory-side outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            waddr_q <= 30'd0;
            be_q    <= 4'd0;
            wd_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= BUSY;
                        cnt_q   <= 16'd0;
                        req_q   <= 1'b1;
                        we_q    <= core_we_i;
                        size_q  <= core_size_i;
                        off_q   <= core_addr_i[1:0];
                        waddr_q <= core_addr_i[31:2];
                        be_q    <= be_d;
                        wd_q    <= wd_d;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed bench for lsu_riscv with a short memory wait budget (4 cycles).
module tb_lsu_riscv;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misaligned_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int n_chk  = 0;
    int n_fail = 0;

    lsu_riscv #(.MEM_TIMEOUT(4)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .core_req_i        (core_req_i),
        .core_we_i         (core_we_i),
        .core_size_i       (core_size_i),
        .core_addr_i       (core_addr_i),
        .core_wd_i         (core_wd_i),
        .core_rd_o         (core_rd_o),
        .core_stall_o      (core_stall_o),
        .core_misaligned_o (core_misaligned_o),
        .core_err_o        (core_err_o),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_be_o          (mem_be_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wd_o          (mem_wd_o),
        .mem_rd_i          (mem_rd_i),
        .mem_ready_i       (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs
    // sampled well away from either clock edge.
    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    // One access that completes in its first BUSY cycle.
    task automatic xact(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        #1;
        chk({tag, ".stall_req"}, 32'(core_stall_o), 32'd1);
        chk({tag, ".memreq_idle"}, 32'(mem_req_o), 32'd0);
        cyc();
        core_req_i  = 1'b0;
        mem_ready_i = 1'b1;
        mem_rd_i    = rdata;
        #1;
        chk({tag, ".memreq"}, 32'(mem_req_o), 32'd1);
        chk({tag, ".we"}, 32'(mem_we_o), 32'(we));
        chk({tag, ".be"}, 32'(mem_be_o), 32'(exp_be));
        chk({tag, ".addr"}, mem_addr_o, {addr[31:2], 2'b00});
        if (we) chk({tag, ".wd"}, mem_wd_o, exp_wd);
        chk({tag, ".stall_done"}, 32'(core_stall_o), 32'd0);
        chk({tag, ".rd"}, core_rd_o, exp_rd);
        cyc();
        mem_ready_i = 1'b0;
        #1;
        chk({tag, ".memreq_after"}, 32'(mem_req_o), 32'd0);
        chk({tag, ".stall_after"}, 32'(core_stall_o), 32'd0);
        chk({tag, ".rd_after"}, core_rd_o, 32'd0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        core_req_i  = 1'b1;
        core_we_i   = 1'b1;
        core_size_i = 3'b010;
        core_addr_i = 32'h0000_0100;
        core_wd_i   = 32'hDEAD_BEEF;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b0;

        // Reset: core outputs quiet despite a valid request, memory side cleared.
        #1;
        chk("rst.stall", 32'(core_stall_o), 32'd0);
        chk("rst.err", 32'(core_err_o), 32'd0);
        chk("rst.mis", 32'(core_misaligned_o), 32'd0);
        chk("rst.rd", core_rd_o, 32'd0);
        cyc();
        cyc();
        chk("rst.memreq", 32'(mem_req_o), 32'd0);
        chk("rst.be", 32'(mem_be_o), 32'd0);
        chk("rst.addr", mem_addr_o, 32'd0);
        chk("rst.wd", mem_wd_o, 32'd0);
        core_req_i = 1'b0;
        rst_ni     = 1'b1;
        cyc();

        // Directed single-cycle accesses.
        xact("lb",  1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 4'b1000, 32'h0, 32'hFFFF_FF80);
        xact("sh",  1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 4'b1100, 32'hABCD_ABCD, 32'h0);
        xact("sb",  1'b1, 3'b000, 32'h0000_0005, 32'h0000_00A5, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        xact("sw",  1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0);
        xact("lh",  1'b0, 3'b001, 32'h0000_0022, 32'h0, 32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001);
        xact("lw",  1'b0, 3'b010, 32'h0000_0030, 32'h0, 32'h8765_4321, 4'b1111, 32'h0, 32'h8765_4321);
        xact("lbu", 1'b0, 3'b100, 32'h0000_0041, 32'h0, 32'h0000_F700, 4'b0010, 32'h0, 32'h0000_00F7);

        // Misaligned word load: pulse only, no access.
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'b010;
        core_addr_i = 32'h0000_3001;
        #1;
        chk("mis.pulse", 32'(core_misaligned_o), 32'd1);
        chk("mis.err", 32'(core_err_o), 32'd0);
        chk("mis.stall", 32'(core_stall_o), 32'd0);
        cyc();
        core_req_i = 1'b0;
        #1;
        chk("mis.memreq", 32'(mem_req_o), 32'd0);
        chk("mis.pulse_off", 32'(core_misaligned_o), 32'd0);

        // Illegal funct3.
        core_req_i  = 1'b1;
        core_size_i = 3'b011;
        core_addr_i = 32'h0000_0000;
        #1;
        chk("ill.err", 32'(core_err_o), 32'd1);
        chk("ill.mis", 32'(core_misaligned_o), 32'd0);
        chk("ill.stall", 32'(core_stall_o), 32'd0);
        cyc();
        core_req_i = 1'b0;
        #1;
        chk("ill.memreq", 32'(mem_req_o), 32'd0);

        // Timeout: no ready, error on the 5th BUSY cycle; illegal requests
        // arriving during BUSY are ignored.
        core_req_i  = 1'b1;
        core_size_i = 3'b010;
        core_addr_i = 32'h0000_0040;
        cyc();
        core_size_i = 3'b011;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("to.stall%0d", i), 32'(core_stall_o), 32'd1);
            chk($sformatf("to.err%0d", i), 32'(core_err_o), 32'd0);
            chk($sformatf("to.memreq%0d", i), 32'(mem_req_o), 32'd1);
            cyc();
        end
        core_req_i = 1'b0;
        #1;
        chk("to.err5", 32'(core_err_o), 32'd1);
        chk("to.stall5", 32'(core_stall_o), 32'd0);
        chk("to.memreq5", 32'(mem_req_o), 32'd1);
        cyc();
        #1;
        chk("to.memreq_after", 32'(mem_req_o), 32'd0);
        chk("to.err_after", 32'(core_err_o), 32'd0);
        chk("to.stall_after", 32'(core_stall_o), 32'd0);

        // Ready and timeout in the same cycle: normal LBU completion.
        core_req_i  = 1'b1;
        core_size_i = 3'b100;
        core_addr_i = 32'h0000_0051;
        cyc();
        core_req_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("tie.stall%0d", i), 32'(core_stall_o), 32'd1);
            cyc();
        end
        mem_ready_i = 1'b1;
        mem_rd_i    = 32'h0000_9A00;
        #1;
        chk("tie.err", 32'(core_err_o), 32'd0);
        chk("tie.stall", 32'(core_stall_o), 32'd0);
        chk("tie.rd", core_rd_o, 32'h0000_009A);
        cyc();
        mem_ready_i = 1'b0;
        #1;
        chk("tie.memreq_after", 32'(mem_req_o), 32'd0);
        chk("tie.err_after", 32'(core_err_o), 32'd0);

        // Reset during BUSY: access dropped silently.
        core_req_i  = 1'b1;
        core_size_i = 3'b001;
        core_addr_i = 32'h0000_0062;
        cyc();
        core_req_i = 1'b0;
        #1;
        chk("rmid.memreq_busy", 32'(mem_req_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rmid.stall", 32'(core_stall_o), 32'd0);
        chk("rmid.err", 32'(core_err_o), 32'd0);
        cyc();
        rst_ni = 1'b1;
        #1;
        chk("rmid.memreq", 32'(mem_req_o), 32'd0);
        chk("rmid.err_after", 32'(core_err_o), 32'd0);
        chk("rmid.be", 32'(mem_be_o), 32'd0);
        xact("lhu", 1'b0, 3'b101, 32'h0000_0010, 32'h0, 32'h0000_F00D, 4'b0011, 32'h0, 32'h0000_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
